// File: rtl/conv1_frame_ctrl_if.sv
// rtl/conv1_frame_ctrl_if.sv - control, image-memory and window-buffer signals of the conv1 frame controller
//
// Signals:
//   start, abort        frame request / cancel from the sequencer
//   img_addr, img_rdata image-memory read address and 1-bit pixel (1-cycle read latency)
//   buf_rst_n, pix_out  clear and pixel stream to the 3x3 window buffer
//   win_valid           window-valid strobe from the window buffer
//   busy, done, err     frame status
//   win_cnt             windows counted in the current frame
// Modports:
//   master  the frame controller
//   slave   the surrounding memory, window buffer and sequencer
interface conv1_frame_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] img_addr;
  logic              img_rdata;
  logic              buf_rst_n;
  logic              pix_out;
  logic              win_valid;
  logic              busy;
  logic              done;
  logic              err;
  logic [9:0]        win_cnt;

  modport master (
    input  start, abort, img_rdata, win_valid,
    output img_addr, buf_rst_n, pix_out, busy, done, err, win_cnt
  );

  modport slave (
    output start, abort, img_rdata, win_valid,
    input  img_addr, buf_rst_n, pix_out, busy, done, err, win_cnt
  );
endinterface

// File: rtl/conv1_frame_ctrl.sv
// rtl/conv1_frame_ctrl.sv - frame sequencer streaming a binary image into a 3x3 window buffer
//
// Parameters: WIDTH/HEIGHT image size, ADDR_W image-memory address width.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    conv1_frame_ctrl_if.master: start/abort in, img_addr out, img_rdata in,
//          buf_rst_n/pix_out out, win_valid in, busy/done/err/win_cnt out
// All outputs are registers; registered outputs are computed from the next state
// so they line up with the state they describe.
module conv1_frame_ctrl #(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  conv1_frame_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(WIDTH);
  localparam logic [9:0]        WIN_TARGET = 10'((WIDTH - 2) * (HEIGHT - 2));
  localparam logic [9:0]        WIN_MAX    = 10'h3FF;
  localparam logic [2:0]        DRAIN_LAST = 3'd7;

  state_t            state, state_n;
  logic              clr_cnt;
  logic [2:0]        drain_cnt;
  logic [ADDR_W-1:0] col, row, col_n, row_n;
  logic              rd_valid;
  logic              start_acc, abort_hit, fetch_last;
  logic [9:0]        win_cnt_n;

  logic [ADDR_W-1:0] img_addr;
  logic              buf_rst_n, pix_out, busy, done, err;
  logic [9:0]        win_cnt;

  assign bus.img_addr  = img_addr;
  assign bus.buf_rst_n = buf_rst_n;
  assign bus.pix_out   = pix_out;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.win_cnt   = win_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    start_acc  = (state == IDLE) && bus.start && !bus.abort;
    abort_hit  = (state != IDLE) && bus.abort;
    fetch_last = (col == COL_LAST) && (row == ROW_LAST);
    state_n    = state;
    col_n      = '0;
    row_n      = '0;
    win_cnt_n  = win_cnt;

    case (state)
      IDLE:    if (start_acc) state_n = CLEAR;
      CLEAR:   if (clr_cnt) state_n = FETCH;
      FETCH:   if (fetch_last) state_n = DRAIN;
      DRAIN:   if (win_cnt == WIN_TARGET || drain_cnt == DRAIN_LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort_hit) state_n = IDLE;

    // col/row always describe the address currently on img_addr; they restart
    // from zero whenever the next cycle is the first of a fetch pass.
    if (state == FETCH && state_n == FETCH) begin
      if (col == COL_LAST) begin
        row_n = row + 1'b1;
      end else begin
        col_n = col + 1'b1;
        row_n = row;
      end
    end

    if (start_acc) begin
      win_cnt_n = '0;
    end else if ((state == FETCH || state == DRAIN) && bus.win_valid && win_cnt != WIN_MAX) begin
      win_cnt_n = win_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt   <= 1'b0;
      drain_cnt <= '0;
      col       <= '0;
      row       <= '0;
      rd_valid  <= 1'b0;
      img_addr  <= '0;
      pix_out   <= 1'b0;
      buf_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      win_cnt   <= '0;
    end else begin
      clr_cnt   <= (state == CLEAR) && (state_n == CLEAR);
      drain_cnt <= (state == DRAIN && state_n == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
      col       <= col_n;
      row       <= row_n;
      img_addr  <= (state_n == FETCH) ? (row_n * ROW_STRIDE + col_n) : '0;
      // rd_valid marks that img_rdata carries a fetched pixel this cycle; an
      // abort flushes it so nothing from the cancelled frame reaches pix_out.
      rd_valid  <= (state == FETCH) && !abort_hit;
      pix_out   <= rd_valid && !abort_hit && bus.img_rdata;
      buf_rst_n <= (state_n != CLEAR) && !abort_hit;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      win_cnt   <= win_cnt_n;
      if (start_acc) begin
        err <= 1'b0;
      end else if (state == DRAIN && state_n == DONE) begin
        err <= (win_cnt_n != WIN_TARGET);
      end
    end
  end

endmodule

// File: tb/tb_conv1_frame_ctrl.sv
// tb/tb_conv1_frame_ctrl.sv - randomized self-checking bench for conv1_frame_ctrl
module tb_conv1_frame_ctrl;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int N    = W * H;
  localparam int W5   = 5;
  localparam int N5   = 25;
  localparam int NONE = -1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  conv1_frame_ctrl_if #(.ADDR_W(10)) bus ();
  conv1_frame_ctrl_if #(.ADDR_W(10)) bus5 ();

  conv1_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  conv1_frame_ctrl #(.WIDTH(W5), .HEIGHT(W5), .ADDR_W(10)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5)
  );

  bit mem  [N];
  bit mem5 [N5];
  int checks = 0;
  int errors = 0;

  // synchronous image memories, one-cycle read latency
  always @(posedge clk) begin
    bus.img_rdata  <= (int'(bus.img_addr) < N) ? mem[int'(bus.img_addr)] : 1'b0;
    bus5.img_rdata <= (int'(bus5.img_addr) < N5) ? mem5[int'(bus5.img_addr)] : 1'b0;
  end

  // a 3x3 window completes when its bottom-right pixel arrives
  function automatic bit is_win(input int k, input int w);
    return ((k % w) >= 2) && ((k / w) >= 2);
  endfunction

  // Runs one 28x28 frame. img: 0 checkerboard, 1 random, 2 all ones.
  // restart_at/abort_at/rst_at are fetch-cycle indices (0 = address 0 issued).
  task automatic frame(input int img, input bit wv_en, input int restart_at,
                       input int abort_at, input int rst_at,
                       output int n_done, output int done_at);
    int c;
    bit fin;
    logic [9:0] exp_addr;
    bit exp_pix;
    for (int i = 0; i < N; i++)
      mem[i] = (img == 0) ? bit'(((i % W) + (i / W)) % 2) :
               (img == 2) ? 1'b1 : bit'($urandom_range(0, 1));
    n_done = 0;
    done_at = -1;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.err !== 1'b0 || bus.win_cnt !== 10'd0) begin
      errors++;
      $display("FAIL start_accept got busy=%b err=%b win_cnt=%0d want 1 0 0", bus.busy, bus.err, bus.win_cnt);
    end
    c = -2;
    fin = 1'b0;
    while (!fin && c < N + 20) begin
      exp_addr = (c >= 0 && c < N) ? 10'(c) : 10'd0;
      exp_pix  = (c >= 2 && c - 2 < N) ? mem[c - 2] : 1'b0;
      checks++;
      if (bus.img_addr !== exp_addr) begin
        errors++; $display("FAIL img_addr c=%0d got %0d want %0d", c, bus.img_addr, exp_addr);
      end
      checks++;
      if (bus.pix_out !== exp_pix) begin
        errors++; $display("FAIL pix_out c=%0d got %b want %b", c, bus.pix_out, exp_pix);
      end
      checks++;
      if (bus.buf_rst_n !== (c >= 0)) begin
        errors++; $display("FAIL buf_rst_n c=%0d got %b want %b", c, bus.buf_rst_n, (c >= 0));
      end
      if (bus.done === 1'b1) begin
        n_done++;
        done_at = c;
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++; $display("FAIL busy_in_done got %b want 1", bus.busy);
        end
      end else if (n_done > 0) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++; $display("FAIL busy_after_done got %b want 0", bus.busy);
        end
        fin = 1'b1;
      end
      bus.win_valid = wv_en && c >= 2 && (c - 2) < N && is_win(c - 2, W);
      bus.start = (c == restart_at);
      if (!fin && c == abort_at) begin
        bus.abort = 1'b1;
        bus.win_valid = 1'b0;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.buf_rst_n !== 1'b0 || bus.pix_out !== 1'b0 ||
            bus.done !== 1'b0 || bus.img_addr !== 10'd0) begin
          errors++;
          $display("FAIL abort_next got busy=%b buf_rst_n=%b pix=%b done=%b addr=%0d want 0 0 0 0 0",
                   bus.busy, bus.buf_rst_n, bus.pix_out, bus.done, bus.img_addr);
        end
        @(negedge clk);
        checks++;
        if (bus.buf_rst_n !== 1'b1 || bus.busy !== 1'b0) begin
          errors++; $display("FAIL abort_recover got buf_rst_n=%b busy=%b want 1 0", bus.buf_rst_n, bus.busy);
        end
        fin = 1'b1;
      end else if (!fin && c == rst_at) begin
        rst_n = 1'b0;
        bus.win_valid = 1'b0;
        #1;
        checks++;
        if (bus.img_addr !== 10'd0 || bus.pix_out !== 1'b0 || bus.buf_rst_n !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.err !== 1'b0 || bus.win_cnt !== 10'd0) begin
          errors++;
          $display("FAIL async_reset got addr=%0d pix=%b buf_rst_n=%b busy=%b done=%b err=%b win_cnt=%0d want all 0",
                   bus.img_addr, bus.pix_out, bus.buf_rst_n, bus.busy, bus.done, bus.err, bus.win_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.buf_rst_n !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          errors++; $display("FAIL reset_release got buf_rst_n=%b busy=%b done=%b want 1 0 0", bus.buf_rst_n, bus.busy, bus.done);
        end
        fin = 1'b1;
      end else if (!fin) begin
        @(negedge clk);
        c++;
      end
    end
    bus.start = 1'b0;
    bus.win_valid = 1'b0;
    checks++;
    if (!fin) begin
      errors++; $display("FAIL frame_timeout got c=%0d want frame end", c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.img_addr !== 10'd0 || bus.pix_out !== 1'b0 || bus.buf_rst_n !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.err !== 1'b0 || bus.win_cnt !== 10'd0) begin
      errors++;
      $display("FAIL reset_values got addr=%0d pix=%b buf_rst_n=%b busy=%b done=%b err=%b win_cnt=%0d want all 0",
               bus.img_addr, bus.pix_out, bus.buf_rst_n, bus.busy, bus.done, bus.err, bus.win_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.buf_rst_n !== 1'b0) begin
      errors++; $display("FAIL buf_rst_n_before_edge got %b want 0", bus.buf_rst_n);
    end
    @(negedge clk);
    checks++;
    if (bus.buf_rst_n !== 1'b1 || bus5.buf_rst_n !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL buf_rst_n_rise got %b/%b busy=%b want 1/1 0", bus.buf_rst_n, bus5.buf_rst_n, bus.busy);
    end
  endtask

  task automatic test_checkerboard();
    int nd, da;
    frame(0, 1'b1, NONE, NONE, NONE, nd, da);
    checks++;
    if (nd != 1) begin errors++; $display("FAIL checker_done_count got %0d want 1", nd); end
    checks++;
    if (da < N || da >= N + 8) begin errors++; $display("FAIL checker_done_cycle got %0d want %0d..%0d", da, N, N + 7); end
    checks++;
    if (bus.win_cnt !== 10'd676 || bus.err !== 1'b0) begin
      errors++; $display("FAIL checker_result got win_cnt=%0d err=%b want 676 0", bus.win_cnt, bus.err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.win_cnt !== 10'd676 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL win_cnt_hold got win_cnt=%0d busy=%b want 676 0", bus.win_cnt, bus.busy);
    end
  endtask

  task automatic test_random_image();
    int nd, da;
    repeat (2) begin
      frame(1, 1'b1, NONE, NONE, NONE, nd, da);
      checks++;
      if (nd != 1 || bus.win_cnt !== 10'd676 || bus.err !== 1'b0) begin
        errors++; $display("FAIL random_frame got done=%0d win_cnt=%0d err=%b want 1 676 0", nd, bus.win_cnt, bus.err);
      end
    end
  endtask

  task automatic test_no_windows();
    int nd, da;
    frame(2, 1'b0, NONE, NONE, NONE, nd, da);
    checks++;
    if (nd != 1 || da != N + 8) begin
      errors++; $display("FAIL drain_timeout got done=%0d at %0d want 1 at %0d", nd, da, N + 8);
    end
    checks++;
    if (bus.err !== 1'b1 || bus.win_cnt !== 10'd0) begin
      errors++; $display("FAIL no_win_result got err=%b win_cnt=%0d want 1 0", bus.err, bus.win_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", bus.err); end
  endtask

  task automatic test_restart_ignored();
    int nd, da;
    frame(1, 1'b1, 300, NONE, NONE, nd, da);
    checks++;
    if (nd != 1 || bus.win_cnt !== 10'd676 || bus.err !== 1'b0) begin
      errors++; $display("FAIL restart_ignored got done=%0d win_cnt=%0d err=%b want 1 676 0", nd, bus.win_cnt, bus.err);
    end
  endtask

  task automatic test_abort();
    int nd, da, at;
    frame(1, 1'b1, NONE, 500, NONE, nd, da);
    checks++;
    if (nd != 0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL abort_500 got done=%0d err=%b want 0 0", nd, bus.err);
    end
    frame(1, 1'b1, NONE, NONE, NONE, nd, da);
    checks++;
    if (nd != 1 || bus.win_cnt !== 10'd676) begin
      errors++; $display("FAIL after_abort got done=%0d win_cnt=%0d want 1 676", nd, bus.win_cnt);
    end
    frame(1, 1'b1, NONE, -1, NONE, nd, da);
    checks++;
    if (nd != 0) begin errors++; $display("FAIL abort_in_clear got done=%0d want 0", nd); end
    at = int'($urandom_range(0, N - 1));
    frame(1, 1'b1, NONE, at, NONE, nd, da);
    checks++;
    if (nd != 0) begin errors++; $display("FAIL abort_random at=%0d got done=%0d want 0", at, nd); end
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.buf_rst_n !== 1'b1) begin
      errors++; $display("FAIL start_abort_idle got busy=%b buf_rst_n=%b want 0 1", bus.busy, bus.buf_rst_n);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_abort_idle2 got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_reset_midframe();
    int nd, da;
    frame(1, 1'b1, NONE, NONE, 100, nd, da);
    checks++;
    if (nd != 0) begin errors++; $display("FAIL reset_mid_done got %0d want 0", nd); end
    frame(0, 1'b1, NONE, NONE, NONE, nd, da);
    checks++;
    if (nd != 1 || bus.win_cnt !== 10'd676 || bus.err !== 1'b0) begin
      errors++; $display("FAIL after_reset got done=%0d win_cnt=%0d err=%b want 1 676 0", nd, bus.win_cnt, bus.err);
    end
  endtask

  task automatic test_small_frame();
    int c, n_addr, n_done;
    bit fin;
    for (int i = 0; i < N5; i++) mem5[i] = 1'b1;
    @(negedge clk); bus5.start = 1'b1;
    @(negedge clk); bus5.start = 1'b0;
    c = -2; n_addr = 0; n_done = 0; fin = 1'b0;
    while (!fin && c < N5 + 20) begin
      if (c >= 0 && c < N5) begin
        checks++;
        if (bus5.img_addr !== 10'(c)) begin
          errors++; $display("FAIL small_addr c=%0d got %0d want %0d", c, bus5.img_addr, c);
        end else n_addr++;
      end
      if (c >= 2 && c - 2 < N5) begin
        checks++;
        if (bus5.pix_out !== 1'b1) begin errors++; $display("FAIL small_pix c=%0d got %b want 1", c, bus5.pix_out); end
      end
      if (bus5.done === 1'b1) n_done++;
      else if (n_done > 0) fin = 1'b1;
      bus5.win_valid = c >= 2 && (c - 2) < N5 && is_win(c - 2, W5);
      @(negedge clk);
      c++;
    end
    bus5.win_valid = 1'b0;
    checks++;
    if (n_addr != N5 || n_done != 1) begin
      errors++; $display("FAIL small_frame got addrs=%0d done=%0d want 25 1", n_addr, n_done);
    end
    checks++;
    if (bus5.win_cnt !== 10'd9 || bus5.err !== 1'b0) begin
      errors++; $display("FAIL small_result got win_cnt=%0d err=%b want 9 0", bus5.win_cnt, bus5.err);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;  bus.abort = 1'b0;  bus.win_valid = 1'b0;
    bus5.start = 1'b0; bus5.abort = 1'b0; bus5.win_valid = 1'b0;
    #1;
    test_reset();
    test_checkerboard();
    test_random_image();
    test_no_windows();
    test_restart_ignored();
    test_abort();
    test_start_abort_idle();
    test_reset_midframe();
    test_small_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv1_frame_ctrl.md
CONV1_FRAME_CTRL -- requirements
Module: conv1_frame_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 28, image columns; HEIGHT, default 28, image rows; ADDR_W, default 10, image-memory address width.
REQ-002 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset; reset rst_n is asynchronous, active-low; clock clk.
REQ-004 The block SHALL have port start, input, 1 bit, frame request; sampled in IDLE only.
REQ-005 The block SHALL have port abort, input, 1 bit, cancels the frame in progress.
REQ-006 The block SHALL have port img_addr, output, ADDR_W bits, image-memory read address.
REQ-007 The block SHALL have port img_rdata, input, 1 bit, binary pixel, valid 1 cycle after img_addr.
REQ-008 The block SHALL have port buf_rst_n, output, 1 bit, active-low clear to the 3x3 window buffer.
REQ-009 The block SHALL have port pix_out, output, 1 bit, pixel stream to the window buffer.
REQ-010 The block SHALL have port win_valid, input, 1 bit, window-valid strobe from the window buffer.
REQ-011 The block SHALL have port busy, output, 1 bit, high from leaving IDLE until re-entering IDLE.
REQ-012 The block SHALL have port done, output, 1 bit, one-cycle frame-complete pulse.
REQ-013 The block SHALL have port err, output, 1 bit, sticky window-count mismatch flag, cleared by the next accepted start.
REQ-014 The block SHALL have port win_cnt, output, 10 bits, number of win_valid strobes counted in the current frame.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, FETCH, DRAIN, DONE.
REQ-016 IDLE SHALL hold busy=0 and buf_rst_n=1, and SHALL leave for CLEAR on start=1.
- start while busy=1 SHALL be ignored, with no queuing.
REQ-017 CLEAR SHALL hold buf_rst_n=0 for exactly 2 cycles, clear win_cnt, clear err, then enter FETCH.
REQ-018 FETCH SHALL issue img_addr = 0,1,...,WIDTH*HEIGHT-1, one address per cycle with no gaps, generated row-major from column and row counters.
- The column counter SHALL wrap at WIDTH-1.
- The row counter SHALL increment on each column wrap.
REQ-019 pix_out SHALL be img_rdata registered for address-aligned streaming.
- The pixel for address k SHALL reach pix_out exactly 2 cycles after img_addr=k.
- pix_out SHALL be 0 whenever no fetched pixel is in flight.
REQ-020 After issuing address WIDTH*HEIGHT-1, the FSM SHALL enter DRAIN.
REQ-021 DRAIN SHALL wait for the pipeline to flush, then enter DONE.
- It SHALL exit once win_cnt reaches (WIDTH-2)*(HEIGHT-2), or after 8 cycles, whichever comes first.
REQ-022 win_cnt SHALL increment on every cycle with win_valid=1 while in FETCH or DRAIN, and SHALL saturate at 1023.
REQ-023 DONE SHALL last 1 cycle with done=1, then return to IDLE. win_cnt SHALL hold its value until the next CLEAR.
REQ-024 On entering DONE, err SHALL be set if win_cnt differs from (WIDTH-2)*(HEIGHT-2); for the defaults the expected count is 676.
REQ-025 abort=1 in any non-IDLE state SHALL apply on the next edge:
- return to IDLE;
- drive buf_rst_n=0 for 1 cycle;
- force pix_out=0;
- no done pulse;
- err unchanged.
REQ-026 abort and start asserted together in IDLE SHALL be ignored; abort has priority.
REQ-027 img_addr SHALL hold 0 outside FETCH.
REQ-028 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-029 While rst_n=0, outputs SHALL be:
- state=IDLE;
- img_addr=0, pix_out=0;
- buf_rst_n=0;
- busy=0, done=0, err=0;
- win_cnt=0.
REQ-030 buf_rst_n SHALL rise on the first clk edge after rst_n deasserts.
REQ-031 Reset asserted mid-frame SHALL abandon the frame immediately, with no done pulse.

Verification
REQ-032 Checkerboard image, start pulse:
- buf_rst_n low for 2 cycles;
- 784 consecutive addresses 0..783;
- pix_out equals the memory bit 2 cycles later;
- done pulses once;
- win_cnt=676, err=0.
REQ-033 win_valid tied low for a full frame -> DRAIN times out after 8 cycles, done=1, err=1, win_cnt=0.
REQ-034 start pulsed again during FETCH at address 300 -> ignored; addresses continue 301..783 and exactly one done pulse occurs.
REQ-035 abort at address 500:
- next cycle IDLE, busy=0;
- buf_rst_n low for 1 cycle;
- no done pulse;
- a subsequent start completes with win_cnt=676.
REQ-036 rst_n asserted at address 100 -> all outputs take reset values asynchronously; after release, a new start completes a normal frame.
REQ-037 WIDTH=HEIGHT=5, all-ones image -> 25 addresses issued, win_cnt=9, err=0.
